// File: rtl/rec_pkg.sv
// Shared types for the record write arbiter: record layout, request payload, FSM encoding.
package rec_pkg;

  localparam int unsigned NLANES = 8;
  localparam int unsigned LANEW  = 8;
  localparam int unsigned BW     = 16;

  typedef struct packed {
    logic [NLANES-1:0][LANEW-1:0] a;
    logic [BW-1:0]                b;
  } rec_t;

  typedef enum logic {
    OP_A = 1'b0,
    OP_B = 1'b1
  } op_e;

  typedef struct packed {
    op_e           op;
    logic [2:0]    idx;
    logic          len;
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LANE0 = 2'd1,
    S_LANE1 = 2'd2
  } state_e;

endpackage

// File: rtl/rec_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant_c
);

  logic rr_ptr;

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_ptr ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (|grant_c) begin
      rr_ptr <= grant_c[0];
    end
  end

endmodule

// File: rtl/rec_write_arbiter.sv
// Single writer of the configuration record: arbitrates two requesters and commits lanes one per cycle.
module rec_write_arbiter
  import rec_pkg::*;
#(
  parameter logic [NLANES*LANEW-1:0] RESET_A = 64'h0,
  parameter logic [BW-1:0]           RESET_B = 16'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  req_t [1:0] req,
  output rec_t       rec_o,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
  localparam logic [1:0] ST_LANE0 = 2'(S_LANE0);
  localparam logic [1:0] ST_LANE1 = 2'(S_LANE1);

  logic [1:0] state, state_nxt;
  logic [1:0] grant;
  req_t       cur, cur_nxt;
  rec_t       rec_nxt;
  logic       done_nxt, err_nxt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .en      (state == ST_IDLE),
    .grant_c (grant)
  );

  assign req_ready = grant;

  // Next-state and commit logic; a 2-lane write ending past lane 7 is rejected before any lane is touched.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    rec_nxt   = rec_o;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|grant) begin
          cur_nxt   = grant[1] ? req[1] : req[0];
          state_nxt = ST_LANE0;
        end
      end
      ST_LANE0: begin
        state_nxt = ST_IDLE;
        if (cur.op == OP_B) begin
          rec_nxt.b = (rec_o.b & ~cur.mask) | (cur.data & cur.mask);
          done_nxt  = 1'b1;
        end else if (cur.len && (cur.idx == 3'(NLANES - 1))) begin
          err_nxt  = 1'b1;
          done_nxt = 1'b1;
        end else begin
          rec_nxt.a[cur.idx] = cur.data[LANEW-1:0];
          if (cur.len) begin
            state_nxt = ST_LANE1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_LANE1: begin
        rec_nxt.a[3'(cur.idx + 3'd1)] = cur.data[2*LANEW-1:LANEW];
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur   <= '0;
      rec_o <= rec_t'({RESET_A, RESET_B});
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      rec_o <= rec_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rec_write_arbiter.sv
// Scoreboard bench for rec_write_arbiter: drivers push expected records on accept, a monitor pops on done.
module tb_rec_write_arbiter;
  import rec_pkg::*;

  typedef struct packed {
    rec_t rec;
    logic err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  req_t [1:0] req = '0;
  rec_t       rec_o;
  logic       busy, done, err;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];
  exp_t exp_item;
  rec_t model = '0;
  logic [1:0] last_grant = 2'b00;
  logic [1:0] exp_grant;

  always #5 clk = ~clk;

  rec_write_arbiter #(.RESET_A(64'h0), .RESET_B(16'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req       (req),
    .rec_o     (rec_o),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input op_e op, input logic [2:0] idx, input logic len,
                              input logic [15:0] data, input logic [15:0] mask);
    req_t q;
    q.op = op; q.idx = idx; q.len = len; q.data = data; q.mask = mask;
    return q;
  endfunction

  function automatic rec_t apply(input rec_t r, input req_t q, output logic e);
    rec_t n = r;
    e = (q.op == OP_A) && q.len && (q.idx == 3'd7);
    if (!e) begin
      if (q.op == OP_B) begin
        n.b = (r.b & ~q.mask) | (q.data & q.mask);
      end else begin
        n.a[q.idx] = q.data[7:0];
        if (q.len) n.a[q.idx + 3'd1] = q.data[15:8];
      end
    end
    return n;
  endfunction

  // Monitor: scoreboard pop on done, one-hot ready, round-robin order.
  always @(negedge clk) begin
    if (req_ready == 2'b11) begin
      n_miss++;
      $display("FAIL ready_onehot: got %b, expected at most one bit", req_ready);
    end
    if (!rst_n) begin
      last_grant = 2'b00;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 80'(done), 80'(0));
        end else begin
          exp_item = sb.pop_front();
          chk("sb_rec", rec_o, exp_item.rec);
          chk("sb_err", 80'(err), 80'(exp_item.err));
        end
      end else if (err) begin
        chk("err_without_done", 80'(err), 80'(0));
      end
      if (req_ready != 2'b00) begin
        if (req_valid == 2'b11) begin
          exp_grant = (last_grant == 2'b01) ? 2'b10 : 2'b01;
          chk("rr_winner", 80'(req_ready), 80'(exp_grant));
        end
        last_grant = req_ready;
      end
    end
  end

  // Raise a request, wait (bounded) for ready, record expectation, drop valid after the accept edge.
  task automatic issue(input int r, input req_t p, output int waited, output time t_acc);
    logic e;
    waited = 0;
    t_acc  = 0;
    req[r] = p;
    req_valid[r] = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready[r]) break;
      waited++;
      if (waited > 40) begin
        chk("accept_timeout", 80'(waited), 80'(40));
        req_valid[r] = 1'b0;
        return;
      end
    end
    t_acc = $time;
    model = apply(model, p, e);
    sb.push_back({model, e});
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    model = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rec", rec_o, 80'h0);
    chk("reset_flags", {busy, done, err, req_ready}, 80'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 80'(sb.size()), 80'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   w0, w1;
    time  t0, t1;

    // Directed writes from requester 0.
    do_reset();
    issue(0, mk(OP_A, 3'd1, 1'b1, 16'h1234, 16'h0), w0, t0);
    issue(0, mk(OP_A, 3'd5, 1'b0, 16'h0042, 16'h0), w0, t0);
    issue(0, mk(OP_B, 3'd0, 1'b0, 16'hFFFF, 16'hFFFF), w0, t0);
    issue(0, mk(OP_B, 3'd0, 1'b0, 16'h0000, 16'h0003), w0, t0);
    drain();
    chk("t1_final", rec_o, 80'h0000_4200_0012_3400_FFFC);

    // Simultaneous requests: req0 first, req1 second.
    do_reset();
    fork
      issue(0, mk(OP_A, 3'd0, 1'b0, 16'h00AA, 16'h0), w0, t0);
      issue(1, mk(OP_A, 3'd0, 1'b0, 16'h0055, 16'h0), w1, t1);
    join
    chk("t2_order", 80'(t0 < t1), 80'(1));
    drain();
    chk("t2_a0", 80'(rec_o.a[0]), 80'h55);

    // Rejected 2-lane write at idx 7.
    issue(0, mk(OP_A, 3'd7, 1'b1, 16'hBEEF, 16'h0), w0, t0);
    chk("t3_busy_e0", 80'(busy), 80'(1));
    @(posedge clk); #1;
    chk("t3_done_err", {done, err, busy}, 80'b110);
    chk("t3_rec", rec_o, 80'h0000_0000_0000_0055_0000);

    // 2-lane write at idx 2: lanes commit on successive edges.
    issue(0, mk(OP_A, 3'd2, 1'b1, 16'hC0DE, 16'h0), w0, t0);
    @(posedge clk); #1;
    chk("t4_e1_a2", 80'(rec_o.a[2]), 80'hDE);
    chk("t4_e1_a3", 80'(rec_o.a[3]), 80'h00);
    chk("t4_e1_done", 80'(done), 80'(0));
    @(posedge clk); #1;
    chk("t4_e2_a3", 80'(rec_o.a[3]), 80'hC0);
    chk("t4_e2_done", 80'(done), 80'(1));
    drain();

    // Asynchronous reset while in LANE1.
    req[0] = mk(OP_A, 3'd4, 1'b1, 16'hABCD, 16'h0);
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy_lane1", {busy, done}, 80'b10);
    #2;
    rst_n = 1'b0;
    model = '0;
    #1;
    chk("t5_rec_reset", rec_o, 80'h0);
    chk("t5_flags", {busy, done, err}, 80'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_done", {done, busy}, 80'h0);
    end

    // req1 held continuously, req0 toggling: grants alternate.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          issue(1, mk(OP_A, 3'(i), 1'b0, 16'(8'h10 + i), 16'h0), w1, t1);
          chk("t6_req1_wait", 80'(w1 <= 4), 80'(1));
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          issue(0, mk(OP_B, 3'd0, 1'b0, 16'(16'h1111 * (j + 1)), 16'h00FF), w0, t0);
          repeat (3) @(posedge clk);
          #1;
        end
      end
    join
    drain();
    chk("t6_final", rec_o, {8'h00, 8'h00, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 16'h0033});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
